hpdcache_victim_arbiter: RTL and testbench

- Shares the single victim-selection resource (directory read + replacement policy) between NREQ requesters, e.g. miss refill, prefetch and CMO.
- Per granted request, sequences a directory-valid read and a replacement query, then returns a one-hot victim way.
- Keeps a table of in-flight way reservations so two outstanding refills never receive the same {set, way}.

---
 rtl/hpdcache_victim_arbiter_if.sv | 61 ++++++
 rtl/hpdcache_victim_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_hpdcache_victim_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hpdcache_victim_arbiter_if.sv
// Handshake and bus bundle for the HPDcache victim arbiter.
// The slave modport is the arbiter; the master modport is its environment
// (requesters, directory, replacement policy, response consumer).
interface hpdcache_victim_arbiter_if #(
  parameter int NREQ       = 2,
  parameter int SETS       = 64,
  parameter int WAYS       = 4,
  parameter int PEND_DEPTH = 4
);
  localparam int SET_W  = $clog2(SETS);
  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SLOT_W = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;

  // Requests: a request transfers on a cycle where req_valid_i[i] and
  // req_ready_o[i] are both high; a requester keeps its valid and payload
  // stable until then. Responses follow the same rule with rsp_valid_o and
  // rsp_ready_i. dir_rd_o, repl_o and rel_i are single-cycle strobes.
  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ-1:0]       req_ready_o;
  logic [NREQ*SET_W-1:0] req_set_i;
  logic [NREQ-1:0]       req_updt_i;

  logic                  dir_rd_o;
  logic [SET_W-1:0]      dir_rd_set_o;
  logic [WAYS-1:0]       dir_valid_i;

  logic                  repl_o;
  logic [SET_W-1:0]      repl_set_o;
  logic [WAYS-1:0]       repl_dir_valid_o;
  logic                  repl_updt_o;
  logic [WAYS-1:0]       victim_way_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [ID_W-1:0]       rsp_id_o;
  logic [WAYS-1:0]       rsp_way_o;
  logic [SLOT_W-1:0]     rsp_slot_o;
  logic                  rsp_err_o;

  logic                  rel_i;
  logic [SLOT_W-1:0]     rel_slot_i;

  // Current arbiter FSM state (IDLE=0, DIR=1, SEL=2, RSP=3).
  logic [1:0]            dbg_state_o;

  modport master (
    output req_valid_i, req_set_i, req_updt_i, dir_valid_i, victim_way_i,
           rsp_ready_i, rel_i, rel_slot_i,
    input  req_ready_o, dir_rd_o, dir_rd_set_o, repl_o, repl_set_o,
           repl_dir_valid_o, repl_updt_o, rsp_valid_o, rsp_id_o, rsp_way_o,
           rsp_slot_o, rsp_err_o, dbg_state_o
  );

  modport slave (
    input  req_valid_i, req_set_i, req_updt_i, dir_valid_i, victim_way_i,
           rsp_ready_i, rel_i, rel_slot_i,
    output req_ready_o, dir_rd_o, dir_rd_set_o, repl_o, repl_set_o,
           repl_dir_valid_o, repl_updt_o, rsp_valid_o, rsp_id_o, rsp_way_o,
           rsp_slot_o, rsp_err_o, dbg_state_o
  );
endinterface

// File: rtl/hpdcache_victim_arbiter.sv
// HPDcache victim arbiter: round-robin shares the directory read and the
// replacement policy between NREQ requesters, and keeps a reservation table
// so two outstanding refills never get the same {set, way}.
// Optional macro HPDCACHE_VICTIM_ARB_PERF_EN adds saturating retry/error
// counters on perf_retry_cnt_o / perf_err_cnt_o.
module hpdcache_victim_arbiter #(
  parameter int NREQ       = 2,
  parameter int SETS       = 64,
  parameter int WAYS       = 4,
  parameter int PEND_DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  hpdcache_victim_arbiter_if.slave bus
`ifdef HPDCACHE_VICTIM_ARB_PERF_EN
  ,
  output logic [15:0] perf_retry_cnt_o,
  output logic [15:0] perf_err_cnt_o
`endif
);
  localparam int SET_W   = $clog2(SETS);
  localparam int ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SLOT_W  = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int RETRY_W = $clog2(WAYS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIR  = 2'd1,
    ST_SEL  = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [ID_W-1:0]     lat_id_q;
  logic [SET_W-1:0]    lat_set_q;
  logic                lat_updt_q;
  logic [RETRY_W-1:0]  retry_q;
  logic [WAYS-1:0]     dv_q;
  logic [WAYS-1:0]     rsp_way_q;
  logic [SLOT_W-1:0]   rsp_slot_q;
  logic                rsp_err_q;

  logic [PEND_DEPTH-1:0] ent_valid_q;
  logic [SET_W-1:0]      ent_set_q [PEND_DEPTH];
  logic [WAYS-1:0]       ent_way_q [PEND_DEPTH];

  logic                win_found, hi_found;
  logic [ID_W-1:0]     win_idx, hi_idx, lo_idx;
  logic                tbl_full;
  logic [SLOT_W-1:0]   free_slot;
  logic [WAYS-1:0]     res_mask;
  logic [WAYS-1:0]     dv_cur;
  logic                grant_en;
  logic                alloc;
  logic                sel_err;
  logic                retry_inc;

  // Round-robin winner, free-slot search and reservation mask of the latched set.
  always_comb begin
    hi_found  = 1'b0;
    win_found = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    // Descending scan so the last hit is the lowest index; "hi" only counts
    // requesters at or above the pointer, giving the wrap-around order.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid_i[i]) begin
        win_found = 1'b1;
        lo_idx    = ID_W'(i);
        if (i >= int'(rr_ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;

    tbl_full  = &ent_valid_q;
    free_slot = '0;
    for (int i = PEND_DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid_q[i]) free_slot = SLOT_W'(i);
    end

    res_mask = '0;
    for (int i = 0; i < PEND_DEPTH; i++) begin
      if (ent_valid_q[i] && (ent_set_q[i] == lat_set_q)) res_mask = res_mask | ent_way_q[i];
    end

    // Directory bits arrive in the first SEL cycle and are held for retries.
    dv_cur = (retry_q == '0) ? bus.dir_valid_i : dv_q;
  end

  // FSM next state and all bus outputs.
  always_comb begin
    state_d              = state_q;
    grant_en             = 1'b0;
    alloc                = 1'b0;
    sel_err              = 1'b0;
    retry_inc            = 1'b0;
    bus.req_ready_o      = '0;
    bus.dir_rd_o         = 1'b0;
    bus.dir_rd_set_o     = '0;
    bus.repl_o           = 1'b0;
    bus.repl_set_o       = '0;
    bus.repl_dir_valid_o = '0;
    bus.repl_updt_o      = 1'b0;
    bus.rsp_valid_o      = 1'b0;
    bus.rsp_id_o         = '0;
    bus.rsp_way_o        = '0;
    bus.rsp_slot_o       = '0;
    bus.rsp_err_o        = 1'b0;
    bus.dbg_state_o      = state_q;
    unique case (state_q)
      ST_IDLE: begin
        // Fullness is checked here so an accepted request always finds a slot.
        if (rst_ni && !tbl_full && win_found) begin
          grant_en                 = 1'b1;
          bus.req_ready_o[win_idx] = 1'b1;
          state_d                  = ST_DIR;
        end
      end
      ST_DIR: begin
        bus.dir_rd_o     = 1'b1;
        bus.dir_rd_set_o = lat_set_q;
        state_d          = ST_SEL;
      end
      ST_SEL: begin
        if (&res_mask) begin
          sel_err = 1'b1;
          state_d = ST_RSP;
        end else begin
          bus.repl_o           = 1'b1;
          bus.repl_set_o       = lat_set_q;
          bus.repl_dir_valid_o = dv_cur | res_mask;
          if ((bus.victim_way_i & res_mask) == '0) begin
            bus.repl_updt_o = lat_updt_q;
            alloc           = 1'b1;
            state_d         = ST_RSP;
          end else begin
            // Collision: force a policy update so the next query moves on.
            bus.repl_updt_o = 1'b1;
            if (int'(retry_q) == WAYS - 1) begin
              sel_err = 1'b1;
              state_d = ST_RSP;
            end else begin
              retry_inc = 1'b1;
            end
          end
        end
      end
      ST_RSP: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_id_o    = lat_id_q;
        bus.rsp_way_o   = rsp_way_q;
        bus.rsp_slot_o  = rsp_slot_q;
        bus.rsp_err_o   = rsp_err_q;
        if (bus.rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, arbitration pointer and latched request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      lat_id_q   <= '0;
      lat_set_q  <= '0;
      lat_updt_q <= 1'b0;
      retry_q    <= '0;
      dv_q       <= '0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        lat_id_q   <= win_idx;
        lat_set_q  <= bus.req_set_i[win_idx*SET_W +: SET_W];
        lat_updt_q <= bus.req_updt_i[win_idx];
        rr_ptr_q   <= (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
      end
      if (state_q == ST_DIR) retry_q <= '0;
      if (retry_inc) retry_q <= retry_q + 1'b1;
      if (state_q == ST_SEL && retry_q == '0) dv_q <= bus.dir_valid_i;
    end
  end

  // Response payload, fixed when SEL resolves and held through RSP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_way_q  <= '0;
      rsp_slot_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (alloc) begin
      rsp_way_q  <= bus.victim_way_i;
      rsp_slot_q <= free_slot;
      rsp_err_q  <= 1'b0;
    end else if (sel_err) begin
      rsp_way_q  <= '0;
      rsp_slot_q <= '0;
      rsp_err_q  <= 1'b1;
    end
  end

  // Reservation table: release then allocate; the allocated slot is free, so
  // a same-cycle release can only hit a different (or invalid) slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_valid_q <= '0;
      for (int i = 0; i < PEND_DEPTH; i++) begin
        ent_set_q[i] <= '0;
        ent_way_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PEND_DEPTH; i++) begin
        if (bus.rel_i && (bus.rel_slot_i == SLOT_W'(i))) ent_valid_q[i] <= 1'b0;
        if (alloc && (free_slot == SLOT_W'(i))) begin
          ent_valid_q[i] <= 1'b1;
          ent_set_q[i]   <= lat_set_q;
          ent_way_q[i]   <= bus.victim_way_i;
        end
      end
    end
  end

`ifdef HPDCACHE_VICTIM_ARB_PERF_EN
  // Saturating counters of collision retries and error responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_retry_cnt_o <= '0;
      perf_err_cnt_o   <= '0;
    end else begin
      if (retry_inc && perf_retry_cnt_o != 16'hffff) perf_retry_cnt_o <= perf_retry_cnt_o + 16'd1;
      if (sel_err && perf_err_cnt_o != 16'hffff) perf_err_cnt_o <= perf_err_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hpdcache_victim_arbiter.sv
// Bench for hpdcache_victim_arbiter: scenario tasks drive the arbiter and
// its environment on the falling edge and compare against a reservation
// table / round-robin reference model kept here.
module tb_hpdcache_victim_arbiter;
  localparam int NREQ       = 2;
  localparam int SETS       = 64;
  localparam int WAYS       = 4;
  localparam int PEND_DEPTH = 8;
  localparam int SET_W      = $clog2(SETS);
  localparam int ID_W       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SLOT_W     = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int RSP_W      = ID_W + WAYS + SLOT_W + 1;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  hpdcache_victim_arbiter_if #(.NREQ(NREQ), .SETS(SETS), .WAYS(WAYS), .PEND_DEPTH(PEND_DEPTH)) bus ();

`ifdef HPDCACHE_VICTIM_ARB_PERF_EN
  logic [15:0] perf_retry_cnt, perf_err_cnt;
`endif

  hpdcache_victim_arbiter #(.NREQ(NREQ), .SETS(SETS), .WAYS(WAYS), .PEND_DEPTH(PEND_DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
`ifdef HPDCACHE_VICTIM_ARB_PERF_EN
    ,
    .perf_retry_cnt_o (perf_retry_cnt),
    .perf_err_cnt_o   (perf_err_cnt)
`endif
  );

  // Reference model: reservation table, round-robin pointer, expected responses.
  bit               m_valid [PEND_DEPTH];
  logic [SET_W-1:0] m_set   [PEND_DEPTH];
  logic [WAYS-1:0]  m_way   [PEND_DEPTH];
  int               m_rr;
  logic [RSP_W-1:0] exp_q[$];
  logic [WAYS-1:0]  vict_q[$];

  function automatic void m_reset();
    for (int i = 0; i < PEND_DEPTH; i++) m_valid[i] = 1'b0;
    m_rr = 0;
    exp_q.delete();
  endfunction

  function automatic logic [WAYS-1:0] m_mask(logic [SET_W-1:0] s);
    logic [WAYS-1:0] r = '0;
    for (int i = 0; i < PEND_DEPTH; i++)
      if (m_valid[i] && m_set[i] == s) r = r | m_way[i];
    return r;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < PEND_DEPTH; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic int m_pick(logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int idx = (m_rr + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Driver: release one slot for one cycle (keeps req_valid as it is).
  task automatic do_release(input int slot);
    bus.rel_i      = 1'b1;
    bus.rel_slot_i = SLOT_W'(slot);
    @(negedge clk);
    bus.rel_i = 1'b0;
    m_valid[slot] = 1'b0;
  endtask

  task automatic release_all();
    for (int i = 0; i < PEND_DEPTH; i++) if (m_valid[i]) do_release(i);
  endtask

  // Driver + checks for one complete transaction from grant to response.
  task automatic txn(input logic [NREQ-1:0] vmask, input logic [NREQ*SET_W-1:0] sets,
                     input logic [NREQ-1:0] updts, input logic [WAYS-1:0] dv,
                     input int stall, input bit sel_rel, output int won, output int got_slot);
    int win, retries, slot;
    bit done, err, updt;
    logic [SET_W-1:0]  set;
    logic [WAYS-1:0]   rm, vic, e_way;
    logic [NREQ-1:0]   exp_rdy;
    logic [SLOT_W-1:0] rs, e_slot;
    logic [RSP_W-1:0]  exp_r, got_r;
    bus.req_valid_i = vmask;
    bus.req_set_i   = sets;
    bus.req_updt_i  = updts;
    bus.rsp_ready_i = 1'b0;
    bus.rel_i       = 1'b0;
    #1;
    win = (m_free() < 0) ? -1 : m_pick(vmask);
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    n_checks++;
    if (bus.req_ready_o !== exp_rdy) begin
      n_fail++;
      $display("FAIL grant got=%b exp=%b", bus.req_ready_o, exp_rdy);
    end
    won = win;
    got_slot = -1;
    if (win < 0) begin
      @(negedge clk);
      bus.req_valid_i = '0;
      return;
    end
    set  = sets[win*SET_W +: SET_W];
    updt = updts[win];
    m_rr = (win + 1) % NREQ;
    @(negedge clk);
    bus.req_valid_i = '0;
    #1;
    n_checks++;
    if (bus.dir_rd_o !== 1'b1 || bus.dir_rd_set_o !== set || bus.repl_o !== 1'b0) begin
      n_fail++;
      $display("FAIL dir_rd got=%b/%0d/%b exp=1/%0d/0", bus.dir_rd_o, bus.dir_rd_set_o, bus.repl_o, set);
    end
    @(negedge clk);
    retries = 0; done = 1'b0; err = 1'b0; slot = 0; vic = '0;
    for (int cyc = 0; cyc < WAYS + 1 && !done; cyc++) begin
      bus.dir_valid_i  = (cyc == 0) ? dv : WAYS'($urandom);
      vic              = (vict_q.size() > 0) ? vict_q.pop_front() : WAYS'(1) << $urandom_range(0, WAYS - 1);
      bus.victim_way_i = vic;
      rs               = SLOT_W'($urandom_range(0, PEND_DEPTH - 1));
      bus.rel_i        = sel_rel && ($urandom_range(0, 2) == 0);
      bus.rel_slot_i   = rs;
      #1;
      rm = m_mask(set);
      if (&rm) begin
        n_checks++;
        if (bus.repl_o !== 1'b0) begin
          n_fail++;
          $display("FAIL repl_full_set got=%b exp=0", bus.repl_o);
        end
        err = 1'b1; done = 1'b1;
      end else begin
        n_checks++;
        if (bus.repl_o !== 1'b1 || bus.repl_set_o !== set || bus.repl_dir_valid_o !== (dv | rm)) begin
          n_fail++;
          $display("FAIL repl got=%b/%0d/%b exp=1/%0d/%b", bus.repl_o, bus.repl_set_o,
                   bus.repl_dir_valid_o, set, dv | rm);
        end
        n_checks++;
        if ((vic & rm) == '0) begin
          if (bus.repl_updt_o !== updt) begin
            n_fail++;
            $display("FAIL repl_updt got=%b exp=%b", bus.repl_updt_o, updt);
          end
          slot = m_free(); done = 1'b1;
        end else begin
          if (bus.repl_updt_o !== 1'b1) begin
            n_fail++;
            $display("FAIL retry_updt got=%b exp=1", bus.repl_updt_o);
          end
          if (retries == WAYS - 1) begin
            err = 1'b1; done = 1'b1;
          end else begin
            retries++;
          end
        end
      end
      // Same-cycle release takes effect after this cycle's lookup.
      if (bus.rel_i) m_valid[rs] = 1'b0;
      if (done && !err) begin
        m_valid[slot] = 1'b1;
        m_set[slot]   = set;
        m_way[slot]   = vic;
      end
      @(negedge clk);
    end
    bus.rel_i = 1'b0; bus.victim_way_i = '0; bus.dir_valid_i = '0;
    e_way  = err ? '0 : vic;
    e_slot = err ? '0 : SLOT_W'(slot);
    exp_q.push_back({ID_W'(win), e_way, e_slot, err});
    got_slot = err ? -1 : slot;
    exp_r = exp_q.pop_front();
    bus.req_valid_i = vmask;
    for (int k = 0; k <= stall; k++) begin
      bus.rsp_ready_i = (k == stall);
      #1;
      got_r = {bus.rsp_id_o, bus.rsp_way_o, bus.rsp_slot_o, bus.rsp_err_o};
      n_checks++;
      if (bus.rsp_valid_o !== 1'b1 || got_r !== exp_r) begin
        n_fail++;
        $display("FAIL rsp got=%b/%b exp=1/%b", bus.rsp_valid_o, got_r, exp_r);
      end
      n_checks++;
      if (bus.req_ready_o !== '0) begin
        n_fail++;
        $display("FAIL grant_in_rsp got=%b exp=0", bus.req_ready_o);
      end
      @(negedge clk);
    end
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = '0;
  endtask

  task automatic test_reset();
    bus.req_valid_i = '1; bus.req_set_i = '0; bus.req_updt_i = '0;
    bus.dir_valid_i = '0; bus.victim_way_i = '0; bus.rsp_ready_i = 1'b0;
    bus.rel_i = 1'b0; bus.rel_slot_i = '0;
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (bus.req_ready_o !== '0 || bus.dir_rd_o !== 1'b0 || bus.repl_o !== 1'b0 ||
        bus.rsp_valid_o !== 1'b0 || bus.rsp_way_o !== '0 || bus.dbg_state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset got=%b/%b/%b/%b/%b/%0d exp=0", bus.req_ready_o, bus.dir_rd_o,
               bus.repl_o, bus.rsp_valid_o, bus.rsp_way_o, bus.dbg_state_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid_i = '0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int w, s;
    vict_q.push_back(4'b1000);
    txn(2'b01, {6'd0, 6'd5}, 2'b00, 4'b0111, 0, 1'b0, w, s);
    release_all();
  endtask

  task automatic test_collision();
    int w, s;
    vict_q.push_back(4'b0010);
    txn(2'b01, {6'd0, 6'd3}, 2'b00, 4'b0000, 0, 1'b0, w, s);
    vict_q.push_back(4'b0010);
    vict_q.push_back(4'b0100);
    txn(2'b01, {6'd0, 6'd3}, 2'b00, 4'b1001, 0, 1'b0, w, s);
    release_all();
  endtask

  task automatic test_all_reserved();
    int w, s;
    for (int i = 0; i < WAYS; i++) begin
      vict_q.push_back(WAYS'(1) << i);
      txn(2'b01, {6'd0, 6'd7}, 2'b01, 4'b1111, 0, 1'b0, w, s);
    end
    txn(2'b01, {6'd0, 6'd7}, 2'b01, 4'b1111, 0, 1'b0, w, s);
    release_all();
    // Three ways of set 9 reserved and the policy keeps pointing at them.
    for (int i = 0; i < WAYS - 1; i++) begin
      vict_q.push_back(WAYS'(1) << i);
      txn(2'b10, {6'd9, 6'd0}, 2'b00, 4'b0000, 0, 1'b0, w, s);
    end
    for (int i = 0; i < WAYS; i++) vict_q.push_back(WAYS'(1) << (i % (WAYS - 1)));
    txn(2'b10, {6'd9, 6'd0}, 2'b00, 4'b0000, 0, 1'b0, w, s);
    release_all();
  endtask

  task automatic test_full();
    int w, s;
    for (int i = 0; i < PEND_DEPTH; i++)
      txn(2'b01, {6'd0, SET_W'(20 + i)}, 2'b00, 4'b0000, 0, 1'b0, w, s);
    bus.req_valid_i = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (bus.req_ready_o !== '0) begin
        n_fail++;
        $display("FAIL full_no_grant got=%b exp=00", bus.req_ready_o);
      end
      @(negedge clk);
    end
    bus.rel_i = 1'b1; bus.rel_slot_i = 3'd2;
    #1;
    n_checks++;
    if (bus.req_ready_o !== '0) begin
      n_fail++;
      $display("FAIL full_rel_cycle got=%b exp=00", bus.req_ready_o);
    end
    @(negedge clk);
    bus.rel_i = 1'b0;
    m_valid[2] = 1'b0;
    txn(2'b11, {6'd40, 6'd41}, 2'b11, 4'b0011, 0, 1'b0, w, s);
    release_all();
  endtask

  task automatic test_back_to_back();
    int w, s;
    for (int i = 0; i < 8; i++) begin
      txn(2'b11, {SET_W'($urandom), SET_W'($urandom)}, NREQ'($urandom), WAYS'($urandom), 0, 1'b0, w, s);
      if (s >= 0) do_release(s);
    end
  endtask

  task automatic test_stall();
    int w, s;
    vict_q.push_back(4'b0001);
    txn(2'b10, {6'd12, 6'd13}, 2'b10, 4'b0110, 5, 1'b0, w, s);
    release_all();
  endtask

  task automatic test_reset_mid();
    int w, s;
    vict_q.push_back(4'b0100);
    txn(2'b01, {6'd0, 6'd11}, 2'b00, 4'b0000, 0, 1'b0, w, s);
    bus.req_valid_i = 2'b01; bus.req_set_i = {6'd0, 6'd11};
    @(negedge clk);
    bus.req_valid_i = 2'b11;
    @(negedge clk);
    bus.dir_valid_i = 4'b0000; bus.victim_way_i = 4'b0100;
    #1;
    n_checks++;
    if (bus.repl_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_in_sel got=%b exp=1", bus.repl_o);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready_o !== '0 || bus.repl_o !== 1'b0 || bus.repl_dir_valid_o !== '0 ||
        bus.dir_rd_o !== 1'b0 || bus.rsp_valid_o !== 1'b0 || bus.dbg_state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid got=%b/%b/%b/%b/%b/%0d exp=0", bus.req_ready_o, bus.repl_o,
               bus.repl_dir_valid_o, bus.dir_rd_o, bus.rsp_valid_o, bus.dbg_state_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    bus.req_valid_i = '0; bus.victim_way_i = '0;
    @(negedge clk);
    // Table must be empty: the old {11, way 2} reservation is gone.
    vict_q.push_back(4'b0100);
    txn(2'b11, {6'd11, 6'd11}, 2'b00, 4'b0000, 0, 1'b0, w, s);
    release_all();
  endtask

  task automatic test_random();
    int w, s;
    for (int i = 0; i < 60; i++) begin
      if (m_free() < 0 || $urandom_range(0, 3) == 0) begin
        int v = $urandom_range(0, PEND_DEPTH - 1);
        if (m_valid[v]) do_release(v);
        else if (m_free() < 0) do_release(0);
      end
      txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)),
          {SET_W'($urandom_range(0, 3)), SET_W'($urandom_range(0, 3))},
          NREQ'($urandom), WAYS'($urandom), $urandom_range(0, 3), 1'b1, w, s);
    end
    release_all();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_collision();
    test_all_reserved();
    test_full();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
